// File: rtl/n64_poll_sequencer.sv
// N64 controller poll sequencer: transmits the command byte plus stop bit on an
// open-drain line, decodes the 32-bit reply, and schedules periodic or on-demand polls.
module n64_poll_sequencer #(
    parameter int unsigned CLK_PER_US     = 100,
    parameter int unsigned POLL_PERIOD_US = 16667,
    parameter int unsigned TIMEOUT_US     = 64,
    parameter logic [7:0]  CMD            = 8'h01
) (
    input  logic        PCLK,
    input  logic        PRESET,
    input  logic        enable,
    input  logic        poll_now,
    input  logic        line_in,
    output logic        line_oe,
    output logic        busy,
    output logic [31:0] buttons,
    output logic        buttons_valid,
    output logic        timeout_err,
    output logic [15:0] poll_count
);
    localparam int unsigned PERIOD_CYC  = POLL_PERIOD_US * CLK_PER_US;
    localparam int unsigned TIMEOUT_CYC = TIMEOUT_US * CLK_PER_US;
    localparam int          PW          = $clog2(PERIOD_CYC);
    localparam int          TW          = $clog2(3 * CLK_PER_US + 1);
    localparam int          OW          = $clog2(TIMEOUT_CYC + 1);

    localparam logic [PW-1:0] PERIOD_LAST = PW'(PERIOD_CYC - 1);
    localparam logic [TW-1:0] ONE_US_LAST = TW'(CLK_PER_US - 1);
    localparam logic [TW-1:0] TWO_US_LAST = TW'(2 * CLK_PER_US - 1);
    localparam logic [TW-1:0] THR_US_LAST = TW'(3 * CLK_PER_US - 1);
    localparam logic [OW-1:0] TIMEOUT_LAST = OW'(TIMEOUT_CYC - 1);

    typedef enum logic [2:0] {
        IDLE, TX_LOW, TX_HIGH, TX_STOP, RX_FALL, RX_SAMPLE, RX_RISE
    } state_t;

    state_t        state_q, state_d;
    logic [2:0]    bitIdx_q, bitIdx_d;
    logic [TW-1:0] timer_q, timer_d;
    logic [OW-1:0] timeout_q, timeout_d;
    logic [31:0]   rxShift_q, rxShift_d;
    logic [5:0]    rxCount_q, rxCount_d;
    logic [31:0]   buttons_q, buttons_d;
    logic          valid_q, valid_d;
    logic          tErr_q, tErr_d;
    logic [15:0]   pollCnt_q, pollCnt_d;
    logic [PW-1:0] periodCnt_q;
    logic          pending_q;
    logic          lineMeta_q, lineS_q, lineP_q;
    logic          start;
    logic          periodWrap;
    logic          curBit;

    assign periodWrap = enable && (periodCnt_q == PERIOD_LAST);
    assign curBit     = CMD[bitIdx_q];

    // Line idles high through the pull-up, so the synchroniser resets to 1 to avoid a false fall.
    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            lineMeta_q  <= 1'b1;
            lineS_q     <= 1'b1;
            lineP_q     <= 1'b1;
            periodCnt_q <= '0;
            pending_q   <= 1'b0;
        end else begin
            lineMeta_q <= line_in;
            lineS_q    <= lineMeta_q;
            lineP_q    <= lineS_q;
            if (!enable || periodWrap) periodCnt_q <= '0;
            else                       periodCnt_q <= periodCnt_q + 1'b1;
            if (start)                      pending_q <= 1'b0;
            else if (poll_now || periodWrap) pending_q <= 1'b1;
        end
    end

    always_comb begin
        state_d   = state_q;
        bitIdx_d  = bitIdx_q;
        timer_d   = timer_q;
        timeout_d = timeout_q;
        rxShift_d = rxShift_q;
        rxCount_d = rxCount_q;
        buttons_d = buttons_q;
        valid_d   = 1'b0;
        tErr_d    = 1'b0;
        pollCnt_d = pollCnt_q;
        start     = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (pending_q) begin
                    start    = 1'b1;
                    bitIdx_d = 3'd7;
                    timer_d  = '0;
                    state_d  = TX_LOW;
                end
            end
            TX_LOW: begin
                if (timer_q == (curBit ? ONE_US_LAST : THR_US_LAST)) begin
                    timer_d = '0;
                    state_d = TX_HIGH;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            TX_HIGH: begin
                if (timer_q == (curBit ? THR_US_LAST : ONE_US_LAST)) begin
                    timer_d = '0;
                    if (bitIdx_q != 3'd0) begin
                        bitIdx_d = bitIdx_q - 3'd1;
                        state_d  = TX_LOW;
                    end else begin
                        state_d = TX_STOP;
                    end
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            TX_STOP: begin
                if (timer_q == ONE_US_LAST) begin
                    timer_d   = '0;
                    timeout_d = '0;
                    rxCount_d = '0;
                    state_d   = RX_FALL;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            // Requiring a high-then-low pair skips the tail of our own stop bit still in the synchroniser.
            RX_FALL: begin
                timeout_d = timeout_q + 1'b1;
                if (timeout_q == TIMEOUT_LAST) begin
                    tErr_d  = 1'b1;
                    state_d = IDLE;
                end else if (lineP_q && !lineS_q) begin
                    timer_d = '0;
                    state_d = RX_SAMPLE;
                end
            end
            RX_SAMPLE: begin
                if (timer_q == TWO_US_LAST) begin
                    rxShift_d = {rxShift_q[30:0], lineS_q};
                    rxCount_d = rxCount_q + 6'd1;
                    if (rxCount_q == 6'd31) begin
                        buttons_d = {rxShift_q[30:0], lineS_q};
                        valid_d   = 1'b1;
                        pollCnt_d = pollCnt_q + 16'd1;
                        state_d   = IDLE;
                    end else begin
                        state_d = RX_RISE;
                    end
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            RX_RISE: begin
                timeout_d = timeout_q + 1'b1;
                if (timeout_q == TIMEOUT_LAST) begin
                    tErr_d  = 1'b1;
                    state_d = IDLE;
                end else if (lineS_q) begin
                    timeout_d = '0;
                    state_d   = RX_FALL;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            state_q   <= IDLE;
            bitIdx_q  <= 3'd7;
            timer_q   <= '0;
            timeout_q <= '0;
            rxShift_q <= '0;
            rxCount_q <= '0;
            buttons_q <= '0;
            valid_q   <= 1'b0;
            tErr_q    <= 1'b0;
            pollCnt_q <= '0;
        end else begin
            state_q   <= state_d;
            bitIdx_q  <= bitIdx_d;
            timer_q   <= timer_d;
            timeout_q <= timeout_d;
            rxShift_q <= rxShift_d;
            rxCount_q <= rxCount_d;
            buttons_q <= buttons_d;
            valid_q   <= valid_d;
            tErr_q    <= tErr_d;
            pollCnt_q <= pollCnt_d;
        end
    end

    assign line_oe       = (state_q == TX_LOW) || (state_q == TX_STOP);
    assign busy          = (state_q != IDLE);
    assign buttons       = buttons_q;
    assign buttons_valid = valid_q;
    assign timeout_err   = tErr_q;
    assign poll_count    = pollCnt_q;
endmodule

// File: tb/tb_n64_poll_sequencer.sv
// Self-checking bench for n64_poll_sequencer with a behavioural controller model
// that answers on the shared open-drain line.
module tb_n64_poll_sequencer;
    localparam int US = 4;

    logic        PCLK = 1'b0;
    logic        PRESET;
    logic        enable;
    logic        poll_now;
    logic        line_in;
    logic        line_oe;
    logic        busy;
    logic [31:0] buttons;
    logic        buttons_valid;
    logic        timeout_err;
    logic [15:0] poll_count;

    logic        ctrlLow = 1'b0;
    logic [31:0] replyWord = '0;
    int          replyBits = 0;
    int          cycleNo = 0;
    int          refCycle = 0;
    int          checks = 0;
    int          errors = 0;

    n64_poll_sequencer #(
        .CLK_PER_US(US), .POLL_PERIOD_US(300), .TIMEOUT_US(16), .CMD(8'h01)
    ) dut (
        .PCLK(PCLK), .PRESET(PRESET), .enable(enable), .poll_now(poll_now),
        .line_in(line_in), .line_oe(line_oe), .busy(busy), .buttons(buttons),
        .buttons_valid(buttons_valid), .timeout_err(timeout_err), .poll_count(poll_count)
    );

    // Open-drain wire: either side pulling low wins over the pull-up.
    assign line_in = ~(line_oe | ctrlLow);

    always #5 PCLK = ~PCLK;
    always @(posedge PCLK) cycleNo <= cycleNo + 1;

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge PCLK);
            #1;
        end
    endtask

    task automatic checkVal(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
        end
    endtask

    // Controller reply: each bit is 4us, low 1us for a 1 or 3us for a 0.
    task automatic sendReply(input logic [31:0] word, input int nBits);
        logic b;
        tick(2 * US);
        for (int i = 0; i < nBits; i++) begin
            b = word[31 - i];
            ctrlLow = 1'b1;
            tick(b ? US : 3 * US);
            ctrlLow = 1'b0;
            refCycle = cycleNo;
            tick(b ? 3 * US : US);
        end
        if (nBits == 32) begin
            ctrlLow = 1'b1;
            tick(US);
            ctrlLow = 1'b0;
        end
    endtask

    // The ninth release of line_oe in a transaction is the end of the console stop bit.
    initial begin : ctrlModel
        int   oeFalls;
        logic prevOe;
        oeFalls = 0;
        prevOe  = 1'b0;
        forever begin
            tick(1);
            if (!busy) oeFalls = 0;
            else if (prevOe && !line_oe) oeFalls++;
            prevOe = line_oe;
            if (oeFalls == 9) begin
                oeFalls  = 0;
                refCycle = cycleNo;
                if (replyBits > 0) sendReply(replyWord, replyBits);
                prevOe = line_oe;
            end
        end
    end

    task automatic waitEnd(input int maxCycles, output bit gotValid, output bit gotErr, output int waited);
        waited = 0;
        while (waited < maxCycles && !buttons_valid && !timeout_err) begin
            tick(1);
            waited++;
        end
        gotValid = buttons_valid;
        gotErr   = timeout_err;
    endtask

    task automatic applyStimulus(input logic [31:0] word, input int nBits);
        replyWord = word;
        replyBits = nBits;
        poll_now  = 1'b1;
        tick(1);
        poll_now  = 1'b0;
    endtask

    typedef struct {
        logic [31:0] word;
        int          bits;
        bit          expValid;
        bit          expErr;
        logic [31:0] expButtons;
        logic [15:0] expCount;
        int          expGap;
    } vec_t;

    task automatic checkOutput(input int idx, input vec_t v);
        bit gotValid, gotErr;
        int waited;
        waitEnd(3000, gotValid, gotErr, waited);
        checkVal($sformatf("vec%0d buttons_valid", idx), gotValid, v.expValid);
        checkVal($sformatf("vec%0d timeout_err", idx), gotErr, v.expErr);
        checkVal($sformatf("vec%0d buttons", idx), buttons, v.expButtons);
        checkVal($sformatf("vec%0d poll_count", idx), poll_count, v.expCount);
        checkVal($sformatf("vec%0d busy", idx), busy, 0);
        if (v.expGap >= 0)
            checkVal($sformatf("vec%0d timeout gap", idx), cycleNo - refCycle, v.expGap);
        tick(1);
        checkVal($sformatf("vec%0d pulse width", idx), buttons_valid | timeout_err, 0);
    endtask

    function automatic logic expOe(input int i);
        if (i < 112) return (i % 16) < 12;
        if (i < 116) return 1'b1;
        if (i < 128) return 1'b0;
        return 1'b1;
    endfunction

    initial begin : watchdog
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin : main
        vec_t vecs[6];
        bit   gotValid, gotErr;
        int   waited, mism, rises, valids, vCycle, rCycle, enStart;
        int   starts[3];
        logic prevBusy;

        // A final 0 bit rises 3 cycles before the synchroniser shows it, hence 64+3 for partial replies.
        vecs[0] = '{32'h8000_0001, 32, 1'b1, 1'b0, 32'h8000_0001, 16'd1, -1};
        vecs[1] = '{32'h1234_5678, 32, 1'b1, 1'b0, 32'h1234_5678, 16'd2, -1};
        vecs[2] = '{32'h0000_0000, 32, 1'b1, 1'b0, 32'h0000_0000, 16'd3, -1};
        vecs[3] = '{32'hFFFF_FFFF, 32, 1'b1, 1'b0, 32'hFFFF_FFFF, 16'd4, -1};
        vecs[4] = '{32'h8000_0001, 32, 1'b1, 1'b0, 32'h8000_0001, 16'd5, -1};
        vecs[5] = '{32'h5A5A_0000, 16, 1'b0, 1'b1, 32'h8000_0001, 16'd5, 67};

        PRESET   = 1'b1;
        enable   = 1'b0;
        poll_now = 1'b0;
        tick(3);
        PRESET = 1'b0;
        checkVal("reset line_oe", line_oe, 0);
        checkVal("reset busy", busy, 0);
        checkVal("reset buttons", buttons, 0);
        checkVal("reset poll_count", poll_count, 0);
        checkVal("reset flags", {buttons_valid, timeout_err}, 0);
        tick(2);

        $display("[TB] no-reply poll: transmit waveform and timeout");
        applyStimulus(32'h0, 0);
        checkVal("start latency busy", busy, 0);
        tick(1);
        mism = 0;
        for (int i = 0; i < 132; i++) begin
            if (line_oe !== expOe(i)) mism++;
            tick(1);
        end
        checkVal("tx waveform mismatches", mism, 0);
        checkVal("released after stop", line_oe, 0);
        waitEnd(200, gotValid, gotErr, waited);
        checkVal("noreply timeout_err", gotErr, 1);
        checkVal("noreply timeout delay", waited, 64);
        checkVal("noreply buttons", buttons, 0);
        checkVal("noreply poll_count", poll_count, 0);
        tick(4);

        $display("[TB] table-driven polls");
        for (int k = 0; k < 6; k++) begin
            applyStimulus(vecs[k].word, vecs[k].bits);
            checkOutput(k, vecs[k]);
            tick(4);
        end

        $display("[TB] periodic polling");
        replyWord = 32'h0000_FFFF;
        replyBits = 32;
        enable    = 1'b1;
        enStart   = cycleNo;
        rises     = 0;
        valids    = 0;
        prevBusy  = 1'b0;
        for (int n = 0; n < 5000 && valids < 3; n++) begin
            tick(1);
            if (busy && !prevBusy && rises < 3) begin
                starts[rises] = cycleNo;
                rises++;
            end
            prevBusy = busy;
            if (buttons_valid) valids++;
        end
        enable = 1'b0;
        checkVal("periodic polls completed", valids, 3);
        checkVal("periodic first start", starts[0] - enStart, 1201);
        checkVal("periodic interval 1", starts[1] - starts[0], 1200);
        checkVal("periodic interval 2", starts[2] - starts[1], 1200);
        checkVal("periodic poll_count", poll_count, 8);
        checkVal("periodic buttons", buttons, 32'h0000_FFFF);
        rises = 0;
        for (int n = 0; n < 1500; n++) begin
            tick(1);
            if (busy && !prevBusy) rises++;
            prevBusy = busy;
        end
        checkVal("no polls while disabled", rises, 0);

        $display("[TB] requests during busy merge into one");
        applyStimulus(32'h8000_0001, 32);
        tick(20);
        poll_now = 1'b1; tick(1); poll_now = 1'b0;
        tick(50);
        poll_now = 1'b1; tick(1); poll_now = 1'b0;
        rises = 0; valids = 0; vCycle = 0; rCycle = 0;
        prevBusy = busy;
        for (int n = 0; n < 2500; n++) begin
            tick(1);
            if (busy && !prevBusy) begin
                rises++;
                rCycle = cycleNo;
            end
            prevBusy = busy;
            if (buttons_valid) begin
                valids++;
                if (valids == 1) vCycle = cycleNo;
            end
        end
        checkVal("merged extra polls", rises, 1);
        checkVal("merged replies", valids, 2);
        checkVal("merged restart gap", rCycle - vCycle, 1);
        checkVal("merged poll_count", poll_count, 10);

        $display("[TB] reset during transmit");
        applyStimulus(32'h0, 0);
        tick(6);
        checkVal("mid TX_LOW line_oe", line_oe, 1);
        PRESET = 1'b1;
        tick(1);
        checkVal("reset mid-tx line_oe", line_oe, 0);
        checkVal("reset mid-tx busy", busy, 0);
        checkVal("reset mid-tx poll_count", poll_count, 0);
        checkVal("reset mid-tx buttons", buttons, 0);
        PRESET = 1'b0;
        tick(3);
        checkVal("no stale request after reset", busy, 0);
        applyStimulus(32'h0F0F_0F0F, 32);
        waitEnd(3000, gotValid, gotErr, waited);
        checkVal("post-reset valid", gotValid, 1);
        checkVal("post-reset buttons", buttons, 32'h0F0F_0F0F);
        checkVal("post-reset poll_count", poll_count, 1);

        tick(10);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
